// File: rtl/bram_stream_pkg.sv
// ---------------------------------------------------------------------------
// bram_stream_pkg
// Shared definitions for the BRAM stream initiator:
//   - state_e      : initiator FSM states
//   - INSTR_W      : width of the instruction word sent to the slave
//   - WR_BIT, ADDR_LSB, LEN_LSB, FIELD_W : instruction field layout
//   - pack_instruct: builds {37'b0, wr, addr[12:0], len[12:0]}
// ---------------------------------------------------------------------------
package bram_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WDATA,
        RDATA,
        DONE
    } state_e;

    localparam int unsigned INSTR_W  = 64;
    localparam int unsigned FIELD_W  = 13;
    localparam int unsigned WR_BIT   = 26;
    localparam int unsigned ADDR_LSB = 13;
    localparam int unsigned LEN_LSB  = 0;

    function automatic logic [INSTR_W-1:0] pack_instruct(
        input logic               wr,
        input logic [FIELD_W-1:0] addr,
        input logic [FIELD_W-1:0] len
    );
        logic [INSTR_W-1:0] w_word;
        w_word                       = '0;
        w_word[WR_BIT]               = wr;
        w_word[ADDR_LSB +: FIELD_W]  = addr;
        w_word[LEN_LSB +: FIELD_W]   = len;
        return w_word;
    endfunction

endpackage

// File: rtl/bram_stream_m.sv
// ---------------------------------------------------------------------------
// bram_stream_m
// Initiator for one BRAM stream slave port. Accepts a {wr, addr, len} job,
// issues the 64-bit instruction word, then either forwards `len` write beats
// into the slave or drains `len` read beats from it.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   s_cmd_*               job command in: {wr, addr, len}
//   m_instruct_*          instruction word out to the slave
//   s_wr_* -> m_in_*      write data path (combinational pass-through)
//   s_out_* -> m_rd_*     read data path (combinational pass-through)
//   busy                  job in progress (state != IDLE)
//   done                  one-cycle pulse at job end
//   err                   sticky tlast/timeout error, cleared on next command
//
// Optional feature: define BRAM_STREAM_M_TIMEOUT_EN to add a stall watchdog
// that abandons a job after TIMEOUT_CYC cycles without a handshake.
// ---------------------------------------------------------------------------
module bram_stream_m
    import bram_stream_pkg::*;
#(
    parameter int unsigned DATA_W      = 1536,
    parameter int unsigned KEEP_W      = 16,
    parameter int unsigned LAST_W      = 24,
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned LEN_W       = 13,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [ADDR_W+LEN_W:0]     s_cmd_tdata,
    input  logic                      s_cmd_tvalid,
    output logic                      s_cmd_tready,

    output logic [INSTR_W-1:0]        m_instruct_tdata,
    output logic                      m_instruct_tvalid,
    input  logic                      m_instruct_tready,

    input  logic [DATA_W-1:0]         s_wr_tdata,
    input  logic                      s_wr_tvalid,
    output logic                      s_wr_tready,

    output logic [DATA_W-1:0]         m_in_tdata,
    output logic                      m_in_tvalid,
    input  logic                      m_in_tready,
    output logic [KEEP_W-1:0]         m_in_tkeep,
    output logic [LAST_W-1:0]         m_in_tlast,

    input  logic [DATA_W-1:0]         s_out_tdata,
    input  logic                      s_out_tvalid,
    output logic                      s_out_tready,
    input  logic [LAST_W-1:0]         s_out_tlast,

    output logic [DATA_W-1:0]         m_rd_tdata,
    output logic                      m_rd_tvalid,
    input  logic                      m_rd_tready,
    output logic                      m_rd_tlast,

    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    state_e                r_state;
    logic                  r_wr;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_beat_cnt;
    logic [INSTR_W-1:0]    r_instruct_tdata;
    logic                  r_instruct_tvalid;
    logic                  r_done;
    logic                  r_err;

    logic                  w_cmd_wr;
    logic [ADDR_W-1:0]     w_cmd_addr;
    logic [LEN_W-1:0]      w_cmd_len;
    logic                  w_last_beat;
    logic                  w_instr_hs;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_active;
    logic                  w_any_hs;
    logic                  w_timeout;

    assign w_cmd_wr   = s_cmd_tdata[ADDR_W+LEN_W];
    assign w_cmd_addr = s_cmd_tdata[ADDR_W+LEN_W-1:LEN_W];
    assign w_cmd_len  = s_cmd_tdata[LEN_W-1:0];

    // Only meaningful in data states, where len is known to be non-zero.
    assign w_last_beat = (r_beat_cnt == r_len - LEN_W'(1));

    // Data paths are pure pass-through, gated off outside their data state.
    assign s_cmd_tready = (r_state == IDLE);
    assign m_in_tvalid  = (r_state == WDATA) && s_wr_tvalid;
    assign s_wr_tready  = (r_state == WDATA) && m_in_tready;
    assign m_in_tdata   = s_wr_tdata;
    assign m_in_tkeep   = '1;
    assign m_in_tlast   = ((r_state == WDATA) && w_last_beat) ? '1 : '0;

    assign m_rd_tvalid  = (r_state == RDATA) && s_out_tvalid;
    assign s_out_tready = (r_state == RDATA) && m_rd_tready;
    assign m_rd_tdata   = s_out_tdata;
    assign m_rd_tlast   = (r_state == RDATA) && w_last_beat;

    assign m_instruct_tdata  = r_instruct_tdata;
    assign m_instruct_tvalid = r_instruct_tvalid;
    assign busy              = (r_state != IDLE);
    assign done              = r_done;
    assign err               = r_err;

    assign w_instr_hs = r_instruct_tvalid && m_instruct_tready;
    assign w_in_hs    = m_in_tvalid && m_in_tready;
    assign w_out_hs   = s_out_tvalid && s_out_tready;
    assign w_active   = (r_state == ISSUE) || (r_state == WDATA) || (r_state == RDATA);
    assign w_any_hs   = w_instr_hs || w_in_hs || w_out_hs;

`ifdef BRAM_STREAM_M_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);

    logic [STALL_W-1:0] r_stall_cnt;
    logic [STALL_W-1:0] w_stall_next;

    assign w_stall_next = r_stall_cnt + STALL_W'(1);
    assign w_timeout    = w_active && !w_any_hs && (w_stall_next == STALL_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!w_active || w_any_hs) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= w_stall_next;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= IDLE;
            r_wr              <= 1'b0;
            r_len             <= '0;
            r_beat_cnt        <= '0;
            r_instruct_tdata  <= '0;
            r_instruct_tvalid <= 1'b0;
            r_done            <= 1'b0;
            r_err             <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (s_cmd_tvalid) begin
                        r_wr              <= w_cmd_wr;
                        r_len             <= w_cmd_len;
                        r_beat_cnt        <= '0;
                        r_err             <= 1'b0;
                        r_instruct_tdata  <= pack_instruct(w_cmd_wr, w_cmd_addr, w_cmd_len);
                        r_instruct_tvalid <= 1'b1;
                        r_state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_instr_hs) begin
                        r_instruct_tvalid <= 1'b0;
                        if (r_len == '0) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= r_wr ? WDATA : RDATA;
                        end
                    end else if (w_timeout) begin
                        r_instruct_tvalid <= 1'b0;
                        r_err             <= 1'b1;
                        r_done            <= 1'b1;
                        r_state           <= DONE;
                    end
                end
                WDATA: begin
                    if (w_in_hs) begin
                        if (w_last_beat) begin
                            r_beat_cnt <= '0;
                            r_done     <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                        end
                    end else if (w_timeout) begin
                        r_beat_cnt <= '0;
                        r_err      <= 1'b1;
                        r_done     <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                RDATA: begin
                    if (w_out_hs) begin
                        // Slave must flag all lanes on the final beat and none before it;
                        // a violation is recorded but the transfer still runs to len beats.
                        if (w_last_beat && (s_out_tlast != '1)) begin
                            r_err <= 1'b1;
                        end
                        if (!w_last_beat && (s_out_tlast != '0)) begin
                            r_err <= 1'b1;
                        end
                        if (w_last_beat) begin
                            r_beat_cnt <= '0;
                            r_done     <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                        end
                    end else if (w_timeout) begin
                        r_beat_cnt <= '0;
                        r_err      <= 1'b1;
                        r_done     <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    r_beat_cnt <= '0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_m.sv
// ---------------------------------------------------------------------------
// tb_bram_stream_m
// Scoreboard bench for bram_stream_m. Expected instruction words and data
// beats are queued when stimulus is driven and compared when the DUT
// completes the corresponding handshake.
// ---------------------------------------------------------------------------
module tb_bram_stream_m;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned KEEP_W = 16;
    localparam int unsigned LAST_W = 24;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned LEN_W  = 13;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic                  clk;
    logic                  rst;
    logic [ADDR_W+LEN_W:0] s_cmd_tdata;
    logic                  s_cmd_tvalid;
    logic                  s_cmd_tready;
    logic [63:0]           m_instruct_tdata;
    logic                  m_instruct_tvalid;
    logic                  m_instruct_tready;
    logic [DATA_W-1:0]     s_wr_tdata;
    logic                  s_wr_tvalid;
    logic                  s_wr_tready;
    logic [DATA_W-1:0]     m_in_tdata;
    logic                  m_in_tvalid;
    logic                  m_in_tready;
    logic [KEEP_W-1:0]     m_in_tkeep;
    logic [LAST_W-1:0]     m_in_tlast;
    logic [DATA_W-1:0]     s_out_tdata;
    logic                  s_out_tvalid;
    logic                  s_out_tready;
    logic [LAST_W-1:0]     s_out_tlast;
    logic [DATA_W-1:0]     m_rd_tdata;
    logic                  m_rd_tvalid;
    logic                  m_rd_tready;
    logic                  m_rd_tlast;
    logic                  busy;
    logic                  done;
    logic                  err;

    bram_stream_m #(
        .DATA_W      (DATA_W),
        .KEEP_W      (KEEP_W),
        .LAST_W      (LAST_W),
        .ADDR_W      (ADDR_W),
        .LEN_W       (LEN_W),
        .TIMEOUT_CYC (16)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .s_cmd_tdata       (s_cmd_tdata),
        .s_cmd_tvalid      (s_cmd_tvalid),
        .s_cmd_tready      (s_cmd_tready),
        .m_instruct_tdata  (m_instruct_tdata),
        .m_instruct_tvalid (m_instruct_tvalid),
        .m_instruct_tready (m_instruct_tready),
        .s_wr_tdata        (s_wr_tdata),
        .s_wr_tvalid       (s_wr_tvalid),
        .s_wr_tready       (s_wr_tready),
        .m_in_tdata        (m_in_tdata),
        .m_in_tvalid       (m_in_tvalid),
        .m_in_tready       (m_in_tready),
        .m_in_tkeep        (m_in_tkeep),
        .m_in_tlast        (m_in_tlast),
        .s_out_tdata       (s_out_tdata),
        .s_out_tvalid      (s_out_tvalid),
        .s_out_tready      (s_out_tready),
        .s_out_tlast       (s_out_tlast),
        .m_rd_tdata        (m_rd_tdata),
        .m_rd_tvalid       (m_rd_tvalid),
        .m_rd_tready       (m_rd_tready),
        .m_rd_tlast        (m_rd_tlast),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned n_instr_hs = 0;
    int unsigned n_in_hs = 0;
    int unsigned n_rd_hs = 0;

    logic [63:0] q_instr[$];
    beat_t       q_in[$];
    beat_t       q_rd[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: pop and compare at every DUT-side handshake.
    beat_t       mon_e;
    logic [63:0] mon_i;
    always @(negedge clk) begin
        if (!rst) begin
            if (m_instruct_tvalid && m_instruct_tready) begin
                n_instr_hs++;
                if (q_instr.size() == 0) begin
                    chk("instr_unexpected", 1, 0);
                end else begin
                    mon_i = q_instr.pop_front();
                    chk("instr_data", m_instruct_tdata, mon_i);
                end
            end
            if (m_in_tvalid && m_in_tready) begin
                n_in_hs++;
                if (q_in.size() == 0) begin
                    chk("in_unexpected", 1, 0);
                end else begin
                    mon_e = q_in.pop_front();
                    chk("in_data", m_in_tdata, mon_e.data);
                    chk("in_tlast", m_in_tlast, mon_e.last ? 24'hFFFFFF : 24'h0);
                    chk("in_tkeep", m_in_tkeep, 16'hFFFF);
                end
            end
            if (m_rd_tvalid && m_rd_tready) begin
                n_rd_hs++;
                if (q_rd.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    mon_e = q_rd.pop_front();
                    chk("rd_data", m_rd_tdata, mon_e.data);
                    chk("rd_tlast", m_rd_tlast, mon_e.last);
                end
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [12:0] addr, input logic [12:0] len);
        bit ok;
        q_instr.push_back({37'b0, wr, addr, len});
        s_cmd_tdata  = {wr, addr, len};
        s_cmd_tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_cmd_tready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_cmd_tvalid = 1'b0;
        if (!ok) chk("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_instr_hs();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_instruct_tvalid && m_instruct_tready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) chk("instr_hs_timeout", 0, 1);
    endtask

    task automatic wr_beats(input int n);
        bit                ok;
        logic [DATA_W-1:0] d;
        for (int b = 0; b < n; b++) begin
            d = {$urandom, $urandom};
            q_in.push_back(beat_t'{data: d, last: (b == n - 1)});
            s_wr_tdata  = d;
            s_wr_tvalid = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (s_wr_tready) begin
                    ok = 1'b1;
                    break;
                end
            end
            @(posedge clk);
            #1;
            if (!ok) chk("wr_beat_timeout", 0, 1);
        end
        s_wr_tvalid = 1'b0;
        chk("wr_done_pulse", done, 1);
    endtask

    // bad_idx >= 0 makes the slave flag full tlast on that non-final beat.
    task automatic rd_beats(input int n, input int bad_idx);
        bit                ok;
        logic [DATA_W-1:0] d;
        for (int b = 0; b < n; b++) begin
            d = {$urandom, $urandom};
            q_rd.push_back(beat_t'{data: d, last: (b == n - 1)});
            s_out_tdata  = d;
            s_out_tvalid = 1'b1;
            s_out_tlast  = ((b == n - 1) || (b == bad_idx)) ? 24'hFFFFFF : 24'h0;
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (s_out_tready) begin
                    ok = 1'b1;
                    break;
                end
            end
            @(posedge clk);
            #1;
            if (!ok) chk("rd_beat_timeout", 0, 1);
            chk("rd_err", err, (bad_idx >= 0) && (b >= bad_idx));
        end
        s_out_tvalid = 1'b0;
        s_out_tlast  = '0;
        chk("rd_done_pulse", done, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int unsigned base_in;
    int unsigned base_rd;
    int          cnt;

    initial begin
        rst               = 1'b1;
        s_cmd_tdata       = '0;
        s_cmd_tvalid      = 1'b0;
        m_instruct_tready = 1'b1;
        s_wr_tdata        = '0;
        s_wr_tvalid       = 1'b0;
        m_in_tready       = 1'b1;
        s_out_tdata       = '0;
        s_out_tvalid      = 1'b0;
        s_out_tlast       = '0;
        m_rd_tready       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_instr_valid", m_instruct_tvalid, 0);
        chk("rst_instr_data", m_instruct_tdata, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write job, addr 5, len 3.
        base_in = n_in_hs;
        q_instr.push_back(64'h0000_0000_0400_A003);
        void'(q_instr.pop_back());
        send_cmd(1'b1, 13'd5, 13'd3);
        chk("t1_instr_word", q_instr.size() == 1 ? q_instr[0] : 64'h0, 64'h0000_0000_0400_A003);
        wr_beats(3);
        chk("t1_beats", n_in_hs - base_in, 3);
        @(posedge clk);
        #1;
        chk("t1_done_one_cycle", done, 0);
        chk("t1_idle", busy, 0);

        // Read job, addr 0x1FFF, len 2, downstream ready toggling.
        base_rd = n_rd_hs;
        send_cmd(1'b0, 13'h1FFF, 13'd2);
        fork
            rd_beats(2, -1);
            begin
                for (int k = 0; k < 8; k++) begin
                    @(posedge clk);
                    #1;
                    m_rd_tready = ~m_rd_tready;
                end
                m_rd_tready = 1'b1;
            end
        join
        m_rd_tready = 1'b1;
        chk("t2_beats", n_rd_hs - base_rd, 2);
        chk("t2_err", err, 0);
        @(posedge clk);
        #1;

        // Read job, len 4, slave flags full tlast early on beat 2.
        base_rd = n_rd_hs;
        send_cmd(1'b0, 13'd9, 13'd4);
        rd_beats(4, 1);
        chk("t3_beats", n_rd_hs - base_rd, 4);
        @(posedge clk);
        #1;
        chk("t3_err_sticky", err, 1);

        // Zero-length job; its acceptance must also clear err.
        base_in = n_in_hs;
        base_rd = n_rd_hs;
        send_cmd(1'b1, 13'h10, 13'd0);
        chk("t4_err_cleared", err, 0);
        wait_instr_hs();
        chk("t4_done", done, 1);
        @(posedge clk);
        #1;
        chk("t4_done_one_cycle", done, 0);
        chk("t4_no_data", (n_in_hs - base_in) + (n_rd_hs - base_rd), 0);

        // Instruction stalled, then reset mid-job.
        m_instruct_tready = 1'b0;
        send_cmd(1'b1, 13'd7, 13'd2);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t5_stall_valid", m_instruct_tvalid, 1);
            chk("t5_stall_data", m_instruct_tdata, 64'h0000_0000_0400_E002);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_instr_valid", m_instruct_tvalid, 0);
        chk("t5_rst_instr_data", m_instruct_tdata, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_valids", {m_in_tvalid, m_rd_tvalid, s_wr_tready, s_out_tready}, 0);
        chk("t5_rst_flags", {done, err}, 0);
        q_instr.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_instruct_tready = 1'b1;
        base_in = n_in_hs;
        send_cmd(1'b1, 13'd3, 13'd1);
        wr_beats(1);
        chk("t5_post_rst_beats", n_in_hs - base_in, 1);
        @(posedge clk);
        #1;

`ifdef BRAM_STREAM_M_TIMEOUT_EN
        // Write job whose upstream never presents data.
        send_cmd(1'b1, 13'd4, 13'd4);
        wait_instr_hs();
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (done) break;
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("t6_stall_cycles", cnt, 16);
        chk("t6_done", done, 1);
        chk("t6_err", err, 1);
        @(posedge clk);
        #1;
        chk("t6_idle", busy, 0);
`endif

        chk("end_q_instr", q_instr.size(), 0);
        chk("end_q_in", q_in.size(), 0);
        chk("end_q_rd", q_rd.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bram_stream_m.md
Name: bram_stream_m

Overview:
- Initiator for the BRAM stream slave.
- Accepts a job command (direction, address, length) and issues the 64-bit instruction word to the slave.
- On a write job, moves `length` beats from an upstream write stream into the slave's input stream. On a read job, drains `length` beats from the slave's output stream to a downstream read stream.
- Sits between the layer scheduler and each BRAM stream slave; one instance per slave port.

Parameters:
- DATA_W, 1536, data beat width
- KEEP_W, 16, tkeep width toward the slave
- LAST_W, 24, per-lane tlast width on the slave interface
- ADDR_W, 13, address field width
- LEN_W, 13, length field width (beats)
- TIMEOUT_CYC, 4096, stall limit; used only with the optional feature

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_cmd_tdata  in  1+ADDR_W+LEN_W  {wr, addr, len}
- s_cmd_tvalid  in  1  command valid
- s_cmd_tready  out  1  command ready
- m_instruct_tdata  out  64  {37'b0, wr, addr[12:0], len[12:0]}: bit 26 = wr, [25:13] = addr, [12:0] = len
- m_instruct_tvalid  out  1  instruction valid
- m_instruct_tready  in  1  instruction ready
- s_wr_tdata  in  DATA_W  upstream write data
- s_wr_tvalid  in  1  upstream write valid
- s_wr_tready  out  1  upstream write ready
- m_in_tdata  out  DATA_W  data to slave
- m_in_tvalid  out  1  data-to-slave valid
- m_in_tready  in  1  data-to-slave ready
- m_in_tkeep  out  KEEP_W  constant all ones
- m_in_tlast  out  LAST_W  all ones on final beat, else zero
- s_out_tdata  in  DATA_W  data from slave
- s_out_tvalid  in  1  data-from-slave valid
- s_out_tready  out  1  data-from-slave ready
- s_out_tlast  in  LAST_W  per-lane last from slave
- m_rd_tdata  out  DATA_W  downstream read data
- m_rd_tvalid  out  1  downstream read valid
- m_rd_tready  in  1  downstream read ready
- m_rd_tlast  out  1  final read beat
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky tlast error; cleared on next command accept

Behaviour:
- Reset (async assert, sync-released flops): state = IDLE, beat_cnt = 0, all valids 0, m_instruct_tdata = 0, done = 0, err = 0, busy = 0.
- FSM states: IDLE, ISSUE, WDATA, RDATA, DONE.
- IDLE: s_cmd_tready = 1. On s_cmd handshake, latch wr/addr/len, clear err, go to ISSUE. The next cycle drives a registered m_instruct_tvalid = 1.
- ISSUE: hold m_instruct_tdata/tvalid stable until m_instruct_tready.
  - On handshake with len == 0: go to DONE; no data phase.
  - Otherwise: go to WDATA if wr, else RDATA.
- WDATA: combinational pass-through.
  - m_in_tvalid = s_wr_tvalid; s_wr_tready = m_in_tready; m_in_tdata = s_wr_tdata.
  - beat_cnt increments per m_in handshake.
  - m_in_tlast = all ones when beat_cnt == len-1.
  - On that handshake: go to DONE.
- RDATA: combinational pass-through.
  - m_rd_tvalid = s_out_tvalid; s_out_tready = m_rd_tready; m_rd_tdata = s_out_tdata.
  - m_rd_tlast = (beat_cnt == len-1).
  - Each s_out handshake checks tlast:
    - s_out_tlast != all ones on the final beat → err = 1.
    - s_out_tlast != 0 on a non-final beat → err = 1.
  - Transfer always continues to len beats.
- DONE: done = 1 for one cycle, beat_cnt = 0, go to IDLE. s_cmd_tready = 0 in this state.
- Outside their data states, s_wr_tready, m_in_tvalid, s_out_tready and m_rd_tvalid are forced to 0.
- Max len = 8191 beats; beat_cnt is LEN_W bits and never wraps.
- Reset mid-job: immediate return to IDLE with all valids 0. The slave must be reset together with this block.

Optional Feature:
BRAM_STREAM_M_TIMEOUT_EN
- Defined: a stall counter resets on any handshake and increments in ISSUE/WDATA/RDATA. At TIMEOUT_CYC it sets err = 1 and forces DONE, which abandons the job.
- Undefined: no counter; the block waits indefinitely.

Decomposition:
- Package bram_stream_pkg holds:
  - state enum
  - instruction bit positions (WR_BIT = 26, ADDR_LSB = 13, LEN_LSB = 0)
  - INSTR_W = 64
  - function pack_instruct(wr, addr, len)
- Sub-module: none required; FSM, beat counter and gating fit in one module.

Test Plan:
- Write, addr 5, len 3, all ready high → instruct 64'h0000_0000_0400_A003; exactly 3 m_in beats; m_in_tlast = 24'hFFFFFF on beat 3 only; done pulses 1 cycle after.
- Read, addr 0x1FFF, len 2, slave tlast correct, m_rd_tready toggling 1/0 → 2 beats forwarded in order, m_rd_tlast on beat 2, err = 0.
- Read, len 4, slave asserts full tlast on beat 2 → err = 1 after beat 2; still 4 beats consumed; err clears on next command accept.
- len = 0 command → instruction issued, no data handshakes, done 1 cycle after the instruct handshake.
- m_instruct_tready held low 10 cycles, then rst pulsed → tvalid/tdata stable while stalled; after rst all outputs 0, busy = 0, next command accepted normally.
- With BRAM_STREAM_M_TIMEOUT_EN and TIMEOUT_CYC = 16, write len 4 with s_wr_tvalid stuck low → err = 1, done asserted after 16 stall cycles, state IDLE.
